battleship_shot_issuer: RTL

//  Attacker-side counterpart of the battleship scorer. Takes player coordinate/bomb entry and

---
 rtl/battleship_pkg.sv | 36 +++
 rtl/battleship_shot_issuer_if.sv | 33 +++
 rtl/rise_edge_detect.sv | 27 ++
 rtl/battleship_shot_issuer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/battleship_pkg.sv
// Shared types and helpers for the battleship shot issuer.
//   coord_t     : 4-bit board coordinate, legal range GRID_MIN..GRID_MAX
//   ship_t      : one-hot ship identifier, bit4 = carrier
//   state_t     : issuer FSM states
//   in_grid     : true when a coordinate is on the board
//   cell_index  : flat 0..99 index of an on-board (x,y) square
package battleship_pkg;

  typedef logic [3:0] coord_t;
  typedef logic [4:0] ship_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    UPDATE,
    DONE
  } state_t;

  localparam coord_t GRID_MIN = 4'd1;
  localparam coord_t GRID_MAX = 4'd10;

  function automatic logic in_grid(coord_t c);
    return (c >= GRID_MIN) && (c <= GRID_MAX);
  endfunction

  // Only meaningful when both coordinates are on the board; callers guard it.
  function automatic logic [6:0] cell_index(coord_t x, coord_t y);
    logic [6:0] col;
    logic [6:0] row;
    col = {3'b000, x} - 7'd1;
    row = {3'b000, y} - 7'd1;
    return (col * 7'd10) + row;
  endfunction

endpackage

// File: rtl/battleship_shot_issuer_if.sv
// Shot request / result channel between the attacker-side issuer and the scorer.
//   shot_valid/shot_ready : request handshake, shot_x/shot_y/shot_big held while valid
//   res_valid             : one-cycle result pulse from the scorer
//   res_hits/near/miss/ship : result payload accompanying res_valid
// master = issuer side, slave = scorer side.
interface battleship_shot_issuer_if;
  import battleship_pkg::*;

  logic       shot_valid;
  logic       shot_ready;
  coord_t     shot_x;
  coord_t     shot_y;
  logic       shot_big;

  logic       res_valid;
  logic [3:0] res_hits;
  logic       res_near;
  logic       res_miss;
  ship_t      res_ship;

  modport master (
    output shot_valid, shot_x, shot_y, shot_big,
    input  shot_ready,
    input  res_valid, res_hits, res_near, res_miss, res_ship
  );

  modport slave (
    input  shot_valid, shot_x, shot_y, shot_big,
    output shot_ready,
    output res_valid, res_hits, res_near, res_miss, res_ship
  );

endinterface

// File: rtl/rise_edge_detect.sv
// Registered rising-edge detector for a level input (used for the fire button).
//   clock : system clock
//   reset : synchronous, active-high
//   in    : level input
//   pulse : one-cycle pulse, registered, one cycle after the rising edge is sampled
module rise_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic in_q;

  // The pulse itself is registered so the downstream decision sees a clean,
  // glitch-free strobe; this adds one cycle of fire-to-issue latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_q  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      in_q  <= in;
      pulse <= in & ~in_q;
    end
  end

endmodule

// File: rtl/battleship_shot_issuer.sv
// Attacker-side shot issuer for the battleship game.
// Validates a player's coordinate/bomb entry on each fire press, issues one shot
// over a valid/ready request channel, waits for the scorer's result pulse and keeps
// the game tallies used by the LED/HEX display logic.
//   clock, reset        : system clock, synchronous active-high reset
//   x_in, y_in, big_in  : player target entry (legal coordinates 1..10)
//   fire                : level fire button, edge-detected internally
//   bus (master)        : shot request channel out, scorer result channel in
//   hit_count           : total ship squares hit, saturating at TOTAL_SHIP_SQUARES
//   big_left            : big bombs still available
//   last_hit/near/miss  : result flags of the last completed shot
//   biggest_ship        : one-hot biggest ship hit by the last completed shot
//   wrong               : last fire rejected or response timed out
//   busy                : a shot is in flight
//   game_over           : every ship square has been hit
module battleship_shot_issuer
  import battleship_pkg::*;
#(
  parameter int TOTAL_SHIP_SQUARES = 19,
  parameter int BIG_BOMBS_INIT     = 2,
  parameter int RESP_TIMEOUT       = 15
) (
  input  logic                     clock,
  input  logic                     reset,
  input  coord_t                   x_in,
  input  coord_t                   y_in,
  input  logic                     big_in,
  input  logic                     fire,
  battleship_shot_issuer_if.master bus,
  output logic [4:0]               hit_count,
  output logic [1:0]               big_left,
  output logic                     last_hit,
  output logic                     last_near,
  output logic                     last_miss,
  output ship_t                    biggest_ship,
  output logic                     wrong,
  output logic                     busy,
  output logic                     game_over
);

  localparam int TW = $clog2(RESP_TIMEOUT + 1);

  state_t        state;
  state_t        state_next;
  logic          fire_pulse;
  logic [TW-1:0] timer;
  logic [99:0]   shot_map;

  logic [3:0]    res_hits_q;
  logic          res_near_q;
  logic          res_miss_q;
  ship_t         res_ship_q;

  logic          on_board;
  logic [6:0]    req_cell;
  logic          already_shot;
  logic          request_ok;

  logic          accept;
  logic          reject;
  logic          handshake;
  logic          timeout;
  logic          capture_res;
  logic          do_update;

  logic [5:0]    hit_sum;
  logic [4:0]    hit_new;

  rise_edge_detect u_fire_edge (
    .clock (clock),
    .reset (reset),
    .in    (fire),
    .pulse (fire_pulse)
  );

  // Request legality. The map lookup is masked for off-board coordinates since the
  // flat index is meaningless there. Duplicates only block small shots; a big bomb
  // may land on a square already shot as long as one is left.
  always_comb begin
    on_board     = in_grid(x_in) && in_grid(y_in);
    req_cell     = cell_index(x_in, y_in);
    already_shot = on_board ? shot_map[req_cell] : 1'b0;
    request_ok   = on_board && (big_in ? (big_left != 2'd0) : !already_shot);
  end

  // Saturating hit tally computed one bit wider so the sum cannot wrap.
  always_comb begin
    hit_sum = {1'b0, hit_count} + {2'b00, res_hits_q};
    hit_new = (hit_sum >= 6'(TOTAL_SHIP_SQUARES)) ? 5'(TOTAL_SHIP_SQUARES) : hit_sum[4:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus one-cycle strobes that tell the datapath what to do.
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    reject      = 1'b0;
    handshake   = 1'b0;
    timeout     = 1'b0;
    capture_res = 1'b0;
    do_update   = 1'b0;
    case (state)
      IDLE: begin
        if (fire_pulse) begin
          if (request_ok) begin
            accept     = 1'b1;
            state_next = ISSUE;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (bus.shot_ready) begin
          handshake  = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        // The cycle with timer == RESP_TIMEOUT-1 is the last chance for a
        // result, giving exactly RESP_TIMEOUT cycles of waiting.
        if (bus.res_valid) begin
          capture_res = 1'b1;
          state_next  = UPDATE;
        end else if (timer == TW'(RESP_TIMEOUT - 1)) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      UPDATE: begin
        do_update  = 1'b1;
        state_next = (hit_new == 5'(TOTAL_SHIP_SQUARES)) ? DONE : IDLE;
      end
      DONE: begin
        state_next = DONE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath registers driven by the FSM strobes. A reset mid-shot simply
  // discards everything, including any spent big bomb.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.shot_x   <= '0;
      bus.shot_y   <= '0;
      bus.shot_big <= 1'b0;
      hit_count    <= '0;
      big_left     <= 2'(BIG_BOMBS_INIT);
      last_hit     <= 1'b0;
      last_near    <= 1'b0;
      last_miss    <= 1'b0;
      biggest_ship <= '0;
      wrong        <= 1'b0;
      shot_map     <= '0;
      timer        <= '0;
      res_hits_q   <= '0;
      res_near_q   <= 1'b0;
      res_miss_q   <= 1'b0;
      res_ship_q   <= '0;
    end else begin
      if (accept) begin
        bus.shot_x         <= x_in;
        bus.shot_y         <= y_in;
        bus.shot_big       <= big_in;
        wrong              <= 1'b0;
        shot_map[req_cell] <= 1'b1;
      end
      if (reject) begin
        wrong <= 1'b1;
      end
      if (handshake) begin
        timer <= '0;
        if (bus.shot_big) begin
          big_left <= big_left - 2'd1;
        end
      end else if (state == WAIT) begin
        timer <= timer + TW'(1);
      end
      if (capture_res) begin
        res_hits_q <= bus.res_hits;
        res_near_q <= bus.res_near;
        res_miss_q <= bus.res_miss;
        res_ship_q <= bus.res_ship;
      end
      if (timeout) begin
        wrong     <= 1'b1;
        last_hit  <= 1'b0;
        last_near <= 1'b0;
        last_miss <= 1'b0;
      end
      if (do_update) begin
        hit_count    <= hit_new;
        last_hit     <= (res_hits_q != 4'd0);
        last_near    <= res_near_q;
        last_miss    <= res_miss_q;
        biggest_ship <= res_ship_q;
      end
    end
  end

  assign bus.shot_valid = (state == ISSUE);
  assign busy           = (state != IDLE) && (state != DONE);
  assign game_over      = (state == DONE);

endmodule
